// File: rtl/fir_decim_fifo.sv
// Accumulate-and-dump decimator for the 3-tap FIR output, followed by a small
// valid/ready FIFO that holds the averaged samples for the next consumer.
module fir_decim_fifo #(
  parameter int LOG2_DECIM = 2,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ACC_W = 8 + LOG2_DECIM;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [LOG2_DECIM-1:0]    phase_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  in_sext;
  logic signed [ACC_W-1:0]  sum;
  logic [7:0]               result;

  logic [7:0]               mem [DEPTH];
  logic [AW-1:0]            rd_ptr_reg;
  logic [AW-1:0]            wr_ptr_reg;
  logic [AW:0]              level_reg;
  logic                     ovf_reg;

  logic push, pop, full, empty, wr_en, drop;

  assign in_sext = {{LOG2_DECIM{in_data[7]}}, in_data};
  assign sum     = (phase_reg == '0) ? in_sext : acc_reg + in_sext;
  // Dropping the low LOG2_DECIM bits of the full-width sum is exactly an
  // arithmetic shift (floor); the remaining 8 bits always hold the average.
  assign result  = sum[ACC_W-1:LOG2_DECIM];

  assign push  = in_valid && (phase_reg == '1);
  assign empty = (level_reg == '0);
  assign full  = (level_reg == FULL_LEVEL);
  assign pop   = !empty && out_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg  <= '0;
      acc_reg    <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else if (clr) begin
      phase_reg  <= '0;
      acc_reg    <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (in_valid) begin
        acc_reg   <= sum;
        phase_reg <= phase_reg + 1'b1;
      end
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (drop) ovf_reg <= 1'b1;
    end
  end

  // Storage carries no reset; the pointers and level alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !clr && !rst) mem[wr_ptr_reg] <= result;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr_reg];
  assign level     = level_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Self-checking bench for fir_decim_fifo: table-driven averaging groups plus
// hand-written sequences for gaps, overflow, full push/pop and resets.
module tb_fir_decim_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [31:0] samples;   // sample 0 in bits [7:0]
    logic [7:0]  expected;
  } vec_t;
  vec_t tbl[8];

  fir_decim_fifo #(.LOG2_DECIM(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Scoreboard: every pop the DUT performs is compared with the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no output", out_data);
      end else begin
        chk("sb_pop", out_data, sb.pop_front());
      end
    end
  end

  task automatic drive(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_group(input logic [31:0] s, input logic [7:0] exp, input bit dropped);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && !dropped) sb.push_back(exp);
      drive(s[8*i +: 8]);
    end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (level != 0 || sb.size() != 0); c++) @(negedge clk);
    chk({name, "_level"}, 32'(level), 0);
    chk({name, "_sb_empty"}, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'hF0F0F0F0, 8'hF0};
    tbl[1] = '{32'h000000FF, 8'hFF};
    tbl[2] = '{32'h7F7F7F7F, 8'h7F};
    tbl[3] = '{32'h80808080, 8'h80};
    tbl[4] = '{32'h38281808, 8'h20};
    tbl[5] = '{32'h04030201, 8'h02};
    tbl[6] = '{32'hFEFFFFFF, 8'hFE};
    tbl[7] = '{32'hF010F010, 8'h00};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic average, then pop on the following edge.
    send_group(32'h38281808, 8'h20, 1'b0);
    @(negedge clk);
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_data", 32'(out_data), 32'h20);
    chk("basic_level", 32'(level), 1);
    @(negedge clk);
    chk("basic_pop_valid", 32'(out_valid), 0);
    chk("basic_pop_data", 32'(out_data), 0);
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      send_group(tbl[v].samples, tbl[v].expected, 1'b0);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", v), 32'(out_valid), 1);
      chk($sformatf("tbl%0d_data", v), 32'(out_data), 32'(tbl[v].expected));
    end
    idle(2);

    // Gapped input: idle cycles must not advance the phase.
    drive(8'h10); idle(1);
    drive(8'h10); idle(1);
    drive(8'h10); idle(1);
    @(negedge clk);
    chk("gap_not_yet", 32'(out_valid), 0);
    @(posedge clk); #1;
    sb.push_back(8'h10);
    drive(8'h10);
    @(negedge clk);
    chk("gap_valid", 32'(out_valid), 1);
    chk("gap_data", 32'(out_data), 32'h10);
    idle(2);
    chk("gap_level", 32'(level), 0);

    // Full FIFO with push and pop on the same edge.
    out_ready = 1'b0;
    for (int g = 1; g <= 4; g++) send_group({4{8'(g * 8'h11)}}, 8'(g * 8'h11), 1'b0);
    @(negedge clk);
    chk("full_level", 32'(level), 4);
    @(posedge clk); #1;
    drive(8'h55); drive(8'h55); drive(8'h55);
    sb.push_back(8'h55);
    out_ready = 1'b1;
    drive(8'h55);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_level", 32'(level), 4);
    chk("pushpop_ovf", 32'(ovf), 0);
    chk("pushpop_head", 32'(out_data), 32'h22);
    drain("pushpop_drain");

    // Overflow: fifth group dropped, ovf sticky until clr.
    out_ready = 1'b0;
    for (int g = 1; g <= 4; g++) send_group({4{8'(g * 8'h10)}}, 8'(g * 8'h10), 1'b0);
    @(negedge clk);
    chk("ovf_pre_level", 32'(level), 4);
    chk("ovf_pre_flag", 32'(ovf), 0);
    @(posedge clk); #1;
    send_group(32'h50505050, 8'h50, 1'b1);
    @(negedge clk);
    chk("ovf_level", 32'(level), 4);
    chk("ovf_flag", 32'(ovf), 1);
    @(posedge clk); #1;
    drain("ovf_drain");
    chk("ovf_sticky", 32'(ovf), 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);

    // Asynchronous reset in the middle of a group with a FIFO entry present.
    out_ready = 1'b0;
    send_group(32'h30303030, 8'h30, 1'b0);
    drive(8'h40); drive(8'h40);
    chk("mid_pre_level", 32'(level), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_data", 32'(out_data), 0);
    chk("async_level", 32'(level), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(8'h10); drive(8'h10);
    @(negedge clk);
    chk("rst_no_leftover", 32'(out_valid), 0);
    @(posedge clk); #1;
    drive(8'h10);
    sb.push_back(8'h10);
    drive(8'h10);
    @(negedge clk);
    chk("rst_after_valid", 32'(out_valid), 1);
    chk("rst_after_data", 32'(out_data), 32'h10);
    idle(2);

    // Same with clr, which also wins over a simultaneous in_valid.
    out_ready = 1'b0;
    send_group(32'h30303030, 8'h30, 1'b0);
    drive(8'h40); drive(8'h40);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h70;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_data", 32'(out_data), 0);
    chk("clr_level", 32'(level), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(8'h10); drive(8'h10); drive(8'h10);
    @(negedge clk);
    chk("clr_no_leftover", 32'(out_valid), 0);
    @(posedge clk); #1;
    sb.push_back(8'h10);
    drive(8'h10);
    @(negedge clk);
    chk("clr_after_valid", 32'(out_valid), 1);
    chk("clr_after_data", 32'(out_data), 32'h10);
    idle(3);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
